// File: rtl/comparator_2bit_dataflow.sv
// Registered unsigned magnitude comparator with one-hot greater/less/equal flags
// and per-outcome saturating event counters.
module comparator_2bit_dataflow #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             greater,
  output logic             less,
  output logic             equal,
  output logic [CNT_W-1:0] greater_cnt,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] equal_cnt
);

  logic gt_c;
  logic lt_c;
  logic eq_c;

  assign gt_c = (a > b);
  assign lt_c = (a < b);
  assign eq_c = (a == b);

  // Index 2 = greater, 1 = less, 0 = equal; only accepted samples are counted.
  logic [2:0]       hit;
  logic [CNT_W-1:0] cnt_reg [3];

  assign hit = {gt_c, lt_c, eq_c} & {3{in_valid}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      greater   <= 1'b0;
      less      <= 1'b0;
      equal     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        greater <= gt_c;
        less    <= lt_c;
        equal   <= eq_c;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_clr) begin
          cnt_reg[gi] <= '0;
        end else if (hit[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign greater_cnt = cnt_reg[2];
  assign less_cnt    = cnt_reg[1];
  assign equal_cnt   = cnt_reg[0];

endmodule

// File: tb/tb_comparator_2bit_dataflow.sv
// Directed bench for comparator_2bit_dataflow: default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation checks.
module tb_comparator_2bit_dataflow;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic       cnt_clr;

  logic       ov, gt, lt, eq;
  logic [7:0] gcnt, lcnt, ecnt;
  logic       s_ov, s_gt, s_lt, s_eq;
  logic [1:0] s_gcnt, s_lcnt, s_ecnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comparator_2bit_dataflow #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(ov), .greater(gt), .less(lt), .equal(eq),
    .greater_cnt(gcnt), .less_cnt(lcnt), .equal_cnt(ecnt)
  );

  comparator_2bit_dataflow #(.WIDTH(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_valid(s_ov), .greater(s_gt), .less(s_lt), .equal(s_eq),
    .greater_cnt(s_gcnt), .less_cnt(s_lcnt), .equal_cnt(s_ecnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at a falling edge; results are sampled at the next falling edge.
  task automatic step(input logic v, input logic [1:0] av, input logic [1:0] bv, input logic clr);
    in_valid = v;
    a        = av;
    b        = bv;
    cnt_clr  = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_f;
    logic [1:0] sa [5];
    logic [1:0] sb [5];
    logic [3:0] sf [5];

    rst_n = 1'b0; in_valid = 1'b1; a = 2'b11; b = 2'b00; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_flags", {ov, gt, lt, eq}, 4'b0000);
    check("reset_cnts", {gcnt, lcnt, ecnt}, 24'h0);
    check("reset_flags_s", {s_ov, s_gt, s_lt, s_eq, s_gcnt, s_lcnt, s_ecnt}, 10'h0);

    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_flags", {ov, gt, lt, eq}, 4'b1100);
    check("post_reset_gcnt", gcnt, 8'd1);
    $display("reset release: flags=%b gcnt=%0d", {ov, gt, lt, eq}, gcnt);

    step(1'b0, 2'b00, 2'b00, 1'b1);
    check("clr_cnts", {gcnt, lcnt, ecnt}, 24'h0);
    check("clr_keeps_flags", {ov, gt, lt, eq}, 4'b0100);

    sa = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00};
    sb = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    sf = '{4'b1001, 4'b1100, 4'b1010, 4'b1100, 4'b1001};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, sa[i], sb[i], 1'b0);
      check($sformatf("seq%0d_flags", i), {ov, gt, lt, eq}, sf[i]);
      $display("seq a=%b b=%b flags=%b", sa[i], sb[i], {ov, gt, lt, eq});
    end
    check("seq_counts", {gcnt, lcnt, ecnt}, {8'd2, 8'd1, 8'd2});

    step(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      step(1'b1, iv[3:2], iv[1:0], 1'b0);
      exp_f = {1'b1, iv[3:2] > iv[1:0], iv[3:2] < iv[1:0], iv[3:2] == iv[1:0]};
      check($sformatf("sweep_a%0d_b%0d", iv[3:2], iv[1:0]), {ov, gt, lt, eq}, exp_f);
      $display("sweep a=%0d b=%0d flags=%b", iv[3:2], iv[1:0], {ov, gt, lt, eq});
    end
    check("sweep_counts", {gcnt, lcnt, ecnt}, {8'd6, 8'd6, 8'd4});

    step(1'b0, 2'b00, 2'b11, 1'b0);
    check("hold1_flags", {ov, gt, lt, eq}, 4'b0001);
    step(1'b0, 2'b11, 2'b00, 1'b0);
    check("hold2_flags", {ov, gt, lt, eq}, 4'b0001);
    check("hold_counts", {gcnt, lcnt, ecnt}, {8'd6, 8'd6, 8'd4});
    $display("hold: flags=%b counts=%0d/%0d/%0d", {ov, gt, lt, eq}, gcnt, lcnt, ecnt);

    step(1'b0, 2'b00, 2'b00, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 2'b01, 2'b01, 1'b0);
      check($sformatf("sat%0d_ecnt_s", i), s_ecnt, (i > 3) ? 2'd3 : 2'(i));
      $display("sat sample %0d: ecnt_s=%0d ecnt=%0d", i, s_ecnt, ecnt);
    end
    check("sat_ecnt_wide", ecnt, 8'd5);

    step(1'b1, 2'b10, 2'b01, 1'b1);
    check("clr_prio_flags_s", {s_ov, s_gt, s_lt, s_eq}, 4'b1100);
    check("clr_prio_cnts_s", {s_gcnt, s_lcnt, s_ecnt}, 6'h0);
    check("clr_prio_cnts", {gcnt, lcnt, ecnt}, 24'h0);

    step(1'b1, 2'b00, 2'b11, 1'b0);
    check("pre_async_flags", {ov, gt, lt, eq}, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    check("async_flags", {ov, gt, lt, eq}, 4'b0000);
    check("async_cnts", {gcnt, lcnt, ecnt}, 24'h0);
    $display("async reset: flags=%b", {ov, gt, lt, eq});
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
